// File: rtl/param_approx_multiplier.sv
// Sequential approximate unsigned multiplier: normalise both operands, multiply the
// top KEEP bits of each, then denormalise the product into a full 2*WIDTH result.
module param_approx_multiplier #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned KEEP  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned CW = $clog2(2 * WIDTH);
    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned PW = 2 * KEEP;
    localparam int unsigned SH = RW - PW;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NORM_A = 3'd1,
        NORM_B = 3'd2,
        MULT   = 3'd3,
        DENORM = 3'd4,
        DONE   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [RW-1:0]    r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [PW-1:0]    prod_c;

    // KEEP x KEEP array multiply on the normalised operand tops
    always_comb begin
        prod_c = PW'(a_q[WIDTH-1 -: KEEP]) * PW'(b_q[WIDTH-1 -: KEEP]);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (a_in == '0 || b_in == '0) begin
                        r_d     = '0;
                        state_d = DONE;
                    end else begin
                        a_d     = a_in;
                        b_d     = b_in;
                        cnt_d   = '0;
                        state_d = NORM_A;
                    end
                end
            end
            NORM_A: begin
                if (a_q[WIDTH-1]) begin
                    state_d = NORM_B;
                end else begin
                    a_d   = a_q << 1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            NORM_B: begin
                if (b_q[WIDTH-1]) begin
                    state_d = MULT;
                end else begin
                    b_d   = b_q << 1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MULT: begin
                r_d     = RW'(prod_c) << SH;
                state_d = DENORM;
            end
            DENORM: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    r_d   = r_q >> 1;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = r_q;

endmodule

// File: tb/tb_param_approx_multiplier.sv
// Directed bench for param_approx_multiplier: default 16/8 instance for approximation
// and timing, plus an exact 8/8 instance for a product sweep and mid-run reset.
module tb_param_approx_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a_in, b_in;
    logic        busy, done;
    logic [31:0] result;

    logic        rst8;
    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] result8;

    int errors = 0;
    int checks = 0;

    param_approx_multiplier dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .result(result)
    );

    param_approx_multiplier #(.WIDTH(8), .KEEP(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .result(result8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one 16-bit operation and check latency, result and one-cycle done
    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input int lat, input string name);
        int n;
        a_in = a; b_in = b; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy after edge 0: got %b want 1", name, busy);
        end
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (done !== 1'b1 || (lat >= 0 && n != lat) || (lat < 0 && n > 1)) begin
            errors++; $display("FAIL %s latency: done=%b at edge %0d want edge %0d", name, done, n, lat);
        end
        checks++;
        if (result !== exp) begin
            errors++; $display("FAIL %s result: got %h want %h", name, result, exp);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
            errors++; $display("FAIL %s after done: done=%b busy=%b result=%h want 0 0 %h",
                               name, done, busy, result, exp);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b);
        int n;
        logic [15:0] exp;
        exp = 16'(a) * 16'(b);
        a8 = a; b8 = b; start8 = 1'b1;
        step();
        start8 = 1'b0;
        n = 0;
        while (done8 !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (done8 !== 1'b1 || result8 !== exp) begin
            errors++; $display("FAIL exact8 %h*%h: done=%b result=%h want %h", a, b, done8, result8, exp);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0; rst8 = 1'b0; start = 1'b0; start8 = 1'b0;
        a_in = '0; b_in = '0; a8 = '0; b8 = '0;
        step(); step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++; $display("FAIL reset16: busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || result8 !== 16'h0) begin
            errors++; $display("FAIL reset8: busy=%b done=%b result=%h want 0 0 0", busy8, done8, result8);
        end
        rst = 1'b1; rst8 = 1'b1;
        step();
    endtask

    task automatic test_approx();
        run16(16'h8000, 16'h8000, 32'h4000_0000, 4,  "msb_set");
        run16(16'h0001, 16'h0001, 32'h0000_0001, 64, "ones");
        run16(16'h1234, 16'h5678, 32'h0616_C000, 12, "approx");
        run16(16'hFFFF, 16'hFFFF, 32'hFE01_0000, 4,  "max");
    endtask

    task automatic test_zero();
        run16(16'h0000, 16'hFFFF, 32'h0, -1, "zero_a");
        run16(16'hABCD, 16'h0000, 32'h0, -1, "zero_b");
    endtask

    // Start pulses while busy must not disturb the running operation
    task automatic test_ignore_start();
        int n;
        a_in = 16'h00FF; b_in = 16'h00FF; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            if (n == 4 || n == 19) begin
                a_in = 16'h1234; b_in = 16'h0003; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || n != 36) begin
            errors++; $display("FAIL ignore latency: done=%b at edge %0d want edge 36", done, n);
        end
        checks++;
        if (result !== 32'h0000_FE01) begin
            errors++; $display("FAIL ignore result: got %h want 0000fe01", result);
        end
        step();
    endtask

    // start held high through DONE is taken on the first IDLE cycle
    task automatic test_back_to_back();
        int n;
        a_in = 16'h8000; b_in = 16'h8000; start = 1'b1;
        step();
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b idle gap: busy=%b done=%b want 0 0", busy, done);
        end
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL b2b reaccept: busy=%b want 1", busy);
        end
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (done !== 1'b1 || n != 4 || result !== 32'h4000_0000) begin
            errors++; $display("FAIL b2b second op: done=%b edge %0d result=%h want 1 4 40000000",
                               done, n, result);
        end
        step();
    endtask

    task automatic test_exact8();
        logic [7:0] vals [10];
        vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h10, 8'h55, 8'h80, 8'hAA, 8'hFF};
        foreach (vals[i]) begin
            foreach (vals[j]) begin
                run8(vals[i], vals[j]);
            end
        end
    endtask

    task automatic test_abort();
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int k = 0; k < 20; k++) step();
        checks++;
        if (busy8 !== 1'b1) begin
            errors++; $display("FAIL abort precondition: busy=%b want 1", busy8);
        end
        rst8 = 1'b0;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || result8 !== 16'h0) begin
            errors++; $display("FAIL abort: busy=%b done=%b result=%h want 0 0 0", busy8, done8, result8);
        end
        step();
        rst8 = 1'b1;
        step();
        run8(8'h03, 8'h05);
    endtask

    initial begin
        test_reset();
        test_approx();
        test_zero();
        test_ignore_start();
        test_back_to_back();
        test_exact8();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
